// File: rtl/ps2_key_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : ps2_key_decoder                                            |
// | Description : Scan-code set 2 parser that turns PS/2 byte strobes into   |
// |               steady left/right/jump held levels plus a change pulse.    |
// |               Handles make codes, F0 break, E0 extended and the E1 Pause |
// |               sequence, with a timeout that abandons stalled prefixes.   |
// |               Optional macro PS2_WASD_EN adds A/D/W as extra sources.    |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module ps2_key_decoder #(
   parameter int PREFIX_TIMEOUT = 2_000_000,
   parameter int CNT_W          = $clog2(PREFIX_TIMEOUT + 1)
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] rx_data,
   input  logic       rx_valid,
   input  logic       rx_err,
   output logic       left,
   output logic       right,
   output logic       jump,
   output logic       key_event
);

   // Parser states
   localparam logic [2:0] ST_IDLE       = 3'd0;
   localparam logic [2:0] ST_EXT        = 3'd1;
   localparam logic [2:0] ST_BRK        = 3'd2;
   localparam logic [2:0] ST_EXT_BRK    = 3'd3;
   localparam logic [2:0] ST_PAUSE_SKIP = 3'd4;

   // Prefix bytes
   localparam logic [7:0] CODE_EXT   = 8'hE0;
   localparam logic [7:0] CODE_BRK   = 8'hF0;
   localparam logic [7:0] CODE_PAUSE = 8'hE1;

   // Mapped key codes (arrows are extended, the rest are not)
   localparam logic [7:0] CODE_LEFT  = 8'h6B;
   localparam logic [7:0] CODE_RIGHT = 8'h74;
   localparam logic [7:0] CODE_UP    = 8'h75;
   localparam logic [7:0] CODE_SPACE = 8'h29;
`ifdef PS2_WASD_EN
   localparam logic [7:0] CODE_A     = 8'h1C;
   localparam logic [7:0] CODE_D     = 8'h23;
   localparam logic [7:0] CODE_W     = 8'h1D;
`endif

   // Bytes still to swallow after E1 (E1 itself excluded)
   localparam logic [2:0]       PAUSE_LEN   = 3'd7;
   localparam logic [CNT_W-1:0] TIMEOUT_VAL = CNT_W'(PREFIX_TIMEOUT);

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q,   cnt_d;
   logic [2:0]       skip_q,  skip_d;

   // Per-source held bits
   logic arrow_left_q,  arrow_left_d;
   logic arrow_right_q, arrow_right_d;
   logic arrow_up_q,    arrow_up_d;
   logic space_q,       space_d;
`ifdef PS2_WASD_EN
   logic wasd_a_q, wasd_a_d;
   logic wasd_d_q, wasd_d_d;
   logic wasd_w_q, wasd_w_d;
`endif

   // Registered outputs
   logic left_q,  left_d;
   logic right_q, right_d;
   logic jump_q,  jump_d;
   logic key_event_q, key_event_d;

   logic accept;
   logic code_done;
   logic code_ext;
   logic code_brk;

   // Prefix parser: tracks where we are in a multi-byte code and the stall timer
   always_comb begin
      accept    = rx_valid & ~rx_err;
      state_d   = state_q;
      cnt_d     = cnt_q;
      skip_d    = skip_q;
      code_done = 1'b0;
      code_ext  = 1'b0;
      code_brk  = 1'b0;

      if (rx_err) begin
         // A corrupted byte makes the rest of the sequence untrustworthy
         state_d = ST_IDLE;
         cnt_d   = '0;
         skip_d  = '0;
      end else if (accept) begin
         // A byte always wins over a simultaneous timeout
         cnt_d = '0;
         case (state_q)
            ST_IDLE: begin
               if (rx_data == CODE_EXT) begin
                  state_d = ST_EXT;
               end else if (rx_data == CODE_BRK) begin
                  state_d = ST_BRK;
               end else if (rx_data == CODE_PAUSE) begin
                  state_d = ST_PAUSE_SKIP;
                  skip_d  = PAUSE_LEN;
               end else begin
                  code_done = 1'b1;
               end
            end
            ST_EXT: begin
               if (rx_data == CODE_BRK) begin
                  state_d = ST_EXT_BRK;
               end else begin
                  code_done = 1'b1;
                  code_ext  = 1'b1;
                  state_d   = ST_IDLE;
               end
            end
            ST_BRK: begin
               code_done = 1'b1;
               code_brk  = 1'b1;
               state_d   = ST_IDLE;
            end
            ST_EXT_BRK: begin
               code_done = 1'b1;
               code_ext  = 1'b1;
               code_brk  = 1'b1;
               state_d   = ST_IDLE;
            end
            ST_PAUSE_SKIP: begin
               // Pause has no break code; its bytes are consumed silently
               skip_d = skip_q - 3'd1;
               if (skip_q <= 3'd1) begin
                  state_d = ST_IDLE;
                  skip_d  = '0;
               end
            end
            default: begin
               state_d = ST_IDLE;
            end
         endcase
      end else if (state_q != ST_IDLE) begin
         if (cnt_q == TIMEOUT_VAL) begin
            state_d = ST_IDLE;
            cnt_d   = '0;
            skip_d  = '0;
         end else begin
            cnt_d = cnt_q + CNT_W'(1);
         end
      end else begin
         cnt_d = '0;
      end
   end

   // Key map: completed codes set or clear the matching source held bit
   always_comb begin
      arrow_left_d  = arrow_left_q;
      arrow_right_d = arrow_right_q;
      arrow_up_d    = arrow_up_q;
      space_d       = space_q;
`ifdef PS2_WASD_EN
      wasd_a_d      = wasd_a_q;
      wasd_d_d      = wasd_d_q;
      wasd_w_d      = wasd_w_q;
`endif

      if (code_done) begin
         if (code_ext) begin
            case (rx_data)
               CODE_LEFT:  arrow_left_d  = ~code_brk;
               CODE_RIGHT: arrow_right_d = ~code_brk;
               CODE_UP:    arrow_up_d    = ~code_brk;
               default:    ;
            endcase
         end else begin
            case (rx_data)
               CODE_SPACE: space_d  = ~code_brk;
`ifdef PS2_WASD_EN
               CODE_A:     wasd_a_d = ~code_brk;
               CODE_D:     wasd_d_d = ~code_brk;
               CODE_W:     wasd_w_d = ~code_brk;
`endif
               default:    ;
            endcase
         end
      end
   end

   // Output levels are the OR of their sources; the pulse flags any level change
   always_comb begin
`ifdef PS2_WASD_EN
      left_d  = arrow_left_d  | wasd_a_d;
      right_d = arrow_right_d | wasd_d_d;
      jump_d  = arrow_up_d    | space_d | wasd_w_d;
`else
      left_d  = arrow_left_d;
      right_d = arrow_right_d;
      jump_d  = arrow_up_d | space_d;
`endif
      key_event_d = (left_d != left_q) | (right_d != right_q) | (jump_d != jump_q);
   end

   // State registers
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q       <= ST_IDLE;
         cnt_q         <= '0;
         skip_q        <= '0;
         arrow_left_q  <= 1'b0;
         arrow_right_q <= 1'b0;
         arrow_up_q    <= 1'b0;
         space_q       <= 1'b0;
`ifdef PS2_WASD_EN
         wasd_a_q      <= 1'b0;
         wasd_d_q      <= 1'b0;
         wasd_w_q      <= 1'b0;
`endif
         left_q        <= 1'b0;
         right_q       <= 1'b0;
         jump_q        <= 1'b0;
         key_event_q   <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         skip_q        <= skip_d;
         arrow_left_q  <= arrow_left_d;
         arrow_right_q <= arrow_right_d;
         arrow_up_q    <= arrow_up_d;
         space_q       <= space_d;
`ifdef PS2_WASD_EN
         wasd_a_q      <= wasd_a_d;
         wasd_d_q      <= wasd_d_d;
         wasd_w_q      <= wasd_w_d;
`endif
         left_q        <= left_d;
         right_q       <= right_d;
         jump_q        <= jump_d;
         key_event_q   <= key_event_d;
      end
   end

   assign left      = left_q;
   assign right     = right_q;
   assign jump      = jump_q;
   assign key_event = key_event_q;

endmodule
`default_nettype wire

// File: tb/tb_ps2_key_decoder.sv
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module      : tb_ps2_key_decoder                                         |
// | Description : Directed bench for ps2_key_decoder with a byte-stream       |
// |               reference model compared every cycle, plus literal checks. |
// | Revision    : 1.0 - initial release                                      |
// +--------------------------------------------------------------------------+
module tb_ps2_key_decoder;

   localparam int TO = 50;

   logic       clk = 1'b0;
   logic       rst;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_err;
   logic       left, right, jump, key_event;

   int n_pass  = 0;
   int n_total = 0;
   int ev_count = 0;
   bit started = 1'b0;

   ps2_key_decoder #(.PREFIX_TIMEOUT(TO)) dut (
      .clk       (clk),
      .rst       (rst),
      .rx_data   (rx_data),
      .rx_valid  (rx_valid),
      .rx_err    (rx_err),
      .left      (left),
      .right     (right),
      .jump      (jump),
      .key_event (key_event)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic act, input logic exp);
      n_total++;
      if (act === exp) n_pass++;
      else $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
   endtask

   task automatic check_int(input string name, input int act, input int exp);
      n_total++;
      if (act == exp) n_pass++;
      else $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
   endtask

   // ---------------- reference model ----------------
   // Works on the byte stream: pending prefixes as flags, a count of bytes
   // still to ignore for Pause, and the number of idle cycles since the last
   // accepted byte (more than TO idle cycles abandons any pending prefix).
   bit          m_ext = 1'b0, m_brk = 1'b0;
   int          m_skip = 0;
   int unsigned idle_cnt = 0;
   bit h_left_arrow = 1'b0, h_right_arrow = 1'b0, h_up = 1'b0, h_space = 1'b0;
`ifdef PS2_WASD_EN
   bit h_a = 1'b0, h_d = 1'b0, h_w = 1'b0;
`endif
   logic exp_left = 1'b0, exp_right = 1'b0, exp_jump = 1'b0, exp_event = 1'b0;

   task automatic apply_code(input bit ext, input bit brk, input logic [7:0] b);
      bit make;
      make = !brk;
      if (ext) begin
         if (b == 8'h6B) h_left_arrow  = make;
         if (b == 8'h74) h_right_arrow = make;
         if (b == 8'h75) h_up          = make;
      end else begin
         if (b == 8'h29) h_space = make;
`ifdef PS2_WASD_EN
         if (b == 8'h1C) h_a = make;
         if (b == 8'h23) h_d = make;
         if (b == 8'h1D) h_w = make;
`endif
      end
   endtask

   task automatic model_byte(input logic [7:0] b);
      if (m_skip > 0) begin
         m_skip--;
      end else if (!m_ext && !m_brk && b == 8'hE0) begin
         m_ext = 1'b1;
      end else if (!m_brk && b == 8'hF0) begin
         m_brk = 1'b1;
      end else if (!m_ext && !m_brk && b == 8'hE1) begin
         m_skip = 7;
      end else begin
         apply_code(m_ext, m_brk, b);
         m_ext = 1'b0;
         m_brk = 1'b0;
      end
   endtask

   always @(posedge clk) begin : model
      logic nl, nr, nj;
      if (rst) begin
         started = 1'b1;
         m_ext = 1'b0; m_brk = 1'b0; m_skip = 0; idle_cnt = 0;
         h_left_arrow = 1'b0; h_right_arrow = 1'b0; h_up = 1'b0; h_space = 1'b0;
`ifdef PS2_WASD_EN
         h_a = 1'b0; h_d = 1'b0; h_w = 1'b0;
`endif
         exp_left = 1'b0; exp_right = 1'b0; exp_jump = 1'b0; exp_event = 1'b0;
      end else begin
         if (rx_err) begin
            m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
         end else if (rx_valid) begin
            if ((m_ext || m_brk || m_skip != 0) && idle_cnt > TO) begin
               m_ext = 1'b0; m_brk = 1'b0; m_skip = 0;
            end
            model_byte(rx_data);
            idle_cnt = 0;
         end else begin
            idle_cnt++;
         end
`ifdef PS2_WASD_EN
         nl = h_left_arrow | h_a;
         nr = h_right_arrow | h_d;
         nj = h_up | h_space | h_w;
`else
         nl = h_left_arrow;
         nr = h_right_arrow;
         nj = h_up | h_space;
`endif
         exp_event = (nl != exp_left) || (nr != exp_right) || (nj != exp_jump);
         exp_left  = nl;
         exp_right = nr;
         exp_jump  = nj;
      end
   end

   // Every-cycle comparison against the model
   always @(negedge clk) begin
      if (started) begin
         check("cyc_left",      left,      exp_left);
         check("cyc_right",     right,     exp_right);
         check("cyc_jump",      jump,      exp_jump);
         check("cyc_key_event", key_event, exp_event);
         if (key_event === 1'b1) ev_count++;
      end
   end

   // ---------------- stimulus ----------------
   task automatic send(input logic [7:0] b, input int gap);
      @(negedge clk);
      rx_data = b; rx_valid = 1'b1; rx_err = 1'b0;
      @(negedge clk);
      rx_data = 8'h00; rx_valid = 1'b0;
      repeat (gap) @(negedge clk);
   endtask

   task automatic send_err(input logic [7:0] b);
      @(negedge clk);
      rx_data = b; rx_valid = 1'b1; rx_err = 1'b1;
      @(negedge clk);
      rx_data = 8'h00; rx_valid = 1'b0; rx_err = 1'b0;
      repeat (4) @(negedge clk);
   endtask

   initial begin : stim
      int ev0;
      rst = 1'b1; rx_data = 8'h00; rx_valid = 1'b0; rx_err = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_left",  left,      1'b0);
      check("rst_right", right,     1'b0);
      check("rst_jump",  jump,      1'b0);
      check("rst_event", key_event, 1'b0);
      rst = 1'b0;
      repeat (4) @(negedge clk);

      // Left arrow press then release
      ev0 = ev_count;
      send(8'hE0, 20); send(8'h6B, 20);
      check("larrow_make", left, 1'b1);
      check_int("larrow_make_events", ev_count - ev0, 1);
      send(8'hE0, 20); send(8'hF0, 20); send(8'h6B, 20);
      check("larrow_break", left, 1'b0);
      check_int("larrow_total_events", ev_count - ev0, 2);

      // Typematic repeat of space
      ev0 = ev_count;
      send(8'h29, 10); send(8'h29, 10); send(8'h29, 10);
      check("space_repeat_jump", jump, 1'b1);
      check_int("space_repeat_events", ev_count - ev0, 1);

      // Two jump sources: releasing space keeps jump held by up arrow
      ev0 = ev_count;
      send(8'hE0, 5); send(8'h75, 5); send(8'hF0, 5); send(8'h29, 5);
      check("jump_two_sources", jump, 1'b1);
      check_int("jump_two_sources_events", ev_count - ev0, 0);
      send(8'hE0, 5); send(8'hF0, 5); send(8'h75, 5);
      check("jump_released", jump, 1'b0);
      check_int("jump_released_events", ev_count - ev0, 1);

      // Pause sequence is swallowed, then right arrow works
      ev0 = ev_count;
      send(8'hE1, 3); send(8'h14, 3); send(8'h77, 3); send(8'hE1, 3);
      send(8'hF0, 3); send(8'h14, 3); send(8'hF0, 3); send(8'h77, 3);
      check_int("pause_events", ev_count - ev0, 0);
      send(8'hE0, 3); send(8'h74, 3);
      check("after_pause_right", right, 1'b1);
      send(8'hE0, 3); send(8'hF0, 3); send(8'h74, 3);
      check("right_released", right, 1'b0);

      // Pause skips exactly seven bytes after E1
      send(8'hE1, 2);
      for (int i = 0; i < 7; i++) send(8'h29, 2);
      check("pause_skips_space", jump, 1'b0);
      send(8'h29, 3);
      check("space_after_pause", jump, 1'b1);
      send(8'hF0, 3); send(8'h29, 3);
      check("space_after_pause_rel", jump, 1'b0);

      // Stalled E0 prefix is abandoned; a prompt one is honoured
      send(8'hE0, 60); send(8'h6B, 5);
      check("timeout_left", left, 1'b0);
      send(8'hE0, 30); send(8'h6B, 5);
      check("in_time_left", left, 1'b1);

      // Error mid-break leaves left held
      send(8'hE0, 3); send(8'hF0, 3); send_err(8'h6B); send(8'h6B, 5);
      check("err_left_held", left, 1'b1);

      // Left and right together; E0 12 is discarded
      send(8'hE0, 3); send(8'h74, 3);
      check("both_left", left, 1'b1);
      check("both_right", right, 1'b1);
      ev0 = ev_count;
      send(8'hE0, 3); send(8'h12, 3);
      check_int("fake_shift_events", ev_count - ev0, 0);

      // Reset mid-sequence clears everything, without a pulse
      send(8'hE0, 2);
      @(negedge clk); rst = 1'b1;
      @(negedge clk);
      check("rstmid_left",  left,      1'b0);
      check("rstmid_right", right,     1'b0);
      check("rstmid_event", key_event, 1'b0);
      rst = 1'b0;
      send(8'h6B, 5);
      check("rstmid_no_ext", left, 1'b0);

      repeat (5) @(negedge clk);
      $display("%0d/%0d checks passed", n_pass, n_total);
      $finish;
   end

endmodule
`default_nettype wire
